// File: rtl/elixirchip_es1_spu_op_nand.sv
// Bitwise NAND of two operands with a clear input, a clock enable and a
// pipeline depth of 0..3 cycles. Stage 1 captures the result (or CLEAR_DATA);
// later stages are plain delay registers. LATENCY=0 gives a combinational path.
module elixirchip_es1_spu_op_nand #(
  parameter int          LATENCY         = 1,
  parameter int          DATA_BITS       = 8,
  parameter type         data_t          = logic [DATA_BITS-1:0],
  parameter data_t       CLEAR_DATA      = '0,
  parameter bit          IMMEDIATE_DATA0 = 1'b0,
  parameter bit          IMMEDIATE_DATA1 = 1'b0,
  parameter              DEVICE          = "RTL",
  parameter              SIMULATION      = "false",
  parameter              DEBUG           = "false"
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  cke,
  input  data_t s_data0,
  input  data_t s_data1,
  input  logic  s_clear,
  input  logic  s_valid,
  output data_t m_data
);

  // The IMMEDIATE_DATA* flags only tell the tools an operand is constant;
  // the logic below is the same either way, so constant folding happens in
  // synthesis. DEVICE/SIMULATION/DEBUG never change cycle behaviour.

  data_t nand_w;
  assign nand_w = ~(s_data0 & s_data1);

  if (LATENCY == 0) begin : g_comb
    // No registers: clear selects the constant, s_valid and cke play no part.
    assign m_data = s_clear ? CLEAR_DATA : nand_w;
  end else begin : g_pipe
    data_t stage_q [LATENCY];
    data_t stage0_d;

    // Next value of stage 1: clear wins over valid, otherwise hold.
    always_comb begin
      // NOTE: assigning the hold value first keeps this block free of latches
      // whatever branch is taken below.
      stage0_d = stage_q[0];
      if (s_clear) begin
        stage0_d = CLEAR_DATA;
      end else if (s_valid) begin
        stage0_d = nand_w;
      end
    end

    // Pipeline registers: async clear to zero, advance only while cke=1.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        // NOTE: every stage is reset, not just the first; these are pipeline
        // flops rather than a RAM, and resetting them all is what guarantees
        // in-flight data is discarded and no X reaches m_data.
        for (int i = 0; i < LATENCY; i++) begin
          stage_q[i] <= '0;
        end
      end else if (cke) begin
        // NOTE: non-blocking assignments make every stage sample its
        // predecessor's old value, so the shift is a true delay line.
        stage_q[0] <= stage0_d;
        for (int i = 1; i < LATENCY; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign m_data = stage_q[LATENCY-1];
  end

endmodule

// File: tb/tb_elixirchip_es1_spu_op_nand.sv
// Self-checking bench: directed vector table on a LATENCY=3 instance, hand
// sequences for reset corner cases, then random stimulus on LATENCY=0..3
// instances compared against a small behavioural pipeline model.
module tb_elixirchip_es1_spu_op_nand;

  logic        clk = 1'b0;
  logic        reset;
  logic        cke;
  logic        s_clear;
  logic        s_valid;
  logic [31:0] d0;
  logic [31:0] d1;

  logic [7:0]  m3;
  logic [4:0]  m0;
  logic [15:0] m1;
  logic [31:0] m2;

  localparam logic [7:0]  CLR3 = 8'd123;
  localparam logic [4:0]  CLR0 = 5'h15;
  localparam logic [15:0] CLR1 = 16'hbeef;
  localparam logic [31:0] CLR2 = 32'h1234_5678;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  elixirchip_es1_spu_op_nand #(
    .LATENCY(3), .DATA_BITS(8), .CLEAR_DATA(CLR3)
  ) u_l3 (
    .clk(clk), .reset(reset), .cke(cke),
    .s_data0(d0[7:0]), .s_data1(d1[7:0]),
    .s_clear(s_clear), .s_valid(s_valid), .m_data(m3)
  );

  elixirchip_es1_spu_op_nand #(
    .LATENCY(0), .DATA_BITS(5), .CLEAR_DATA(CLR0)
  ) u_l0 (
    .clk(clk), .reset(reset), .cke(cke),
    .s_data0(d0[4:0]), .s_data1(d1[4:0]),
    .s_clear(s_clear), .s_valid(s_valid), .m_data(m0)
  );

  elixirchip_es1_spu_op_nand #(
    .LATENCY(1), .DATA_BITS(16), .CLEAR_DATA(CLR1), .IMMEDIATE_DATA1(1'b1)
  ) u_l1 (
    .clk(clk), .reset(reset), .cke(cke),
    .s_data0(d0[15:0]), .s_data1(d1[15:0]),
    .s_clear(s_clear), .s_valid(s_valid), .m_data(m1)
  );

  elixirchip_es1_spu_op_nand #(
    .LATENCY(2), .DATA_BITS(32), .CLEAR_DATA(CLR2), .DEVICE("ULTRASCALE")
  ) u_l2 (
    .clk(clk), .reset(reset), .cke(cke),
    .s_data0(d0), .s_data1(d1),
    .s_clear(s_clear), .s_valid(s_valid), .m_data(m2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       clr;
    logic       vld;
    logic       ce;
    logic [7:0] exp;   // m_data seen just after this row's edge
  } vec_t;

  vec_t vecs [17];

  // Random-phase reference model: mdl[l][s] is stage s of the LATENCY=l pipe.
  logic [31:0] mdl [1:3][0:2];

  function automatic logic [31:0] width_mask(input int l);
    case (l)
      0:       return 32'h0000_001f;
      1:       return 32'h0000_ffff;
      2:       return 32'hffff_ffff;
      default: return 32'h0000_00ff;
    endcase
  endfunction

  function automatic logic [31:0] clear_of(input int l);
    case (l)
      0:       return {27'd0, CLR0};
      1:       return {16'd0, CLR1};
      2:       return CLR2;
      default: return {24'd0, CLR3};
    endcase
  endfunction

  task automatic model_edge();
    if (cke) begin
      for (int l = 1; l <= 3; l++) begin
        for (int s = l - 1; s > 0; s--) mdl[l][s] = mdl[l][s-1];
        if (s_clear)      mdl[l][0] = clear_of(l);
        else if (s_valid) mdl[l][0] = ~(d0 & d1) & width_mask(l);
      end
    end
  endtask

  initial begin
    // Directed stream: columns a, b, clear, valid, cke, expected m_data.
    vecs[0]  = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00};
    vecs[1]  = '{8'hfe, 8'hff, 1'b0, 1'b1, 1'b1, 8'h00};
    vecs[2]  = '{8'h80, 8'h80, 1'b0, 1'b1, 1'b1, 8'hff};
    vecs[3]  = '{8'hff, 8'hff, 1'b0, 1'b1, 1'b1, 8'h01};
    vecs[4]  = '{8'h5a, 8'ha5, 1'b0, 1'b1, 1'b1, 8'h7f};
    vecs[5]  = '{8'haa, 8'h23, 1'b0, 1'b1, 1'b0, 8'h7f};  // cke=0: frozen, dropped
    vecs[6]  = '{8'h22, 8'h23, 1'b0, 1'b1, 1'b1, 8'h00};
    vecs[7]  = '{8'h75, 8'h75, 1'b0, 1'b1, 1'b1, 8'hff};
    vecs[8]  = '{8'h99, 8'h99, 1'b1, 1'b1, 1'b1, 8'hdd};  // clear beats valid
    vecs[9]  = '{8'h99, 8'h99, 1'b0, 1'b0, 1'b1, 8'h8a};  // valid=0: stage 1 holds
    vecs[10] = '{8'h99, 8'h99, 1'b0, 1'b0, 1'b1, 8'h7b};
    vecs[11] = '{8'h99, 8'h99, 1'b0, 1'b0, 1'b1, 8'h7b};
    vecs[12] = '{8'h99, 8'h99, 1'b0, 1'b0, 1'b1, 8'h7b};
    vecs[13] = '{8'h0f, 8'hf0, 1'b0, 1'b1, 1'b1, 8'h7b};
    vecs[14] = '{8'hff, 8'hff, 1'b1, 1'b0, 1'b1, 8'h7b};  // clear with valid=0
    vecs[15] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'hff};
    vecs[16] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h7b};

    reset = 1'b0; cke = 1'b1; s_clear = 1'b0; s_valid = 1'b1;
    d0 = 32'hffff_ffff; d1 = 32'h0000_0000;
    #2;
    check("reset_l3", {24'd0, m3}, 32'h0);
    check("reset_l1", {16'd0, m1}, 32'h0);
    check("reset_l2", m2, 32'h0);
    check("comb_l0_nand", {27'd0, m0}, 32'h1f);
    s_clear = 1'b1; #1;
    check("comb_l0_clear", {27'd0, m0}, {27'd0, CLR0});
    s_clear = 1'b0;
    tick(); tick();
    check("reset_held_l3", {24'd0, m3}, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 17; i++) begin
      d0[7:0] = vecs[i].a; d1[7:0] = vecs[i].b;
      s_clear = vecs[i].clr; s_valid = vecs[i].vld; cke = vecs[i].ce;
      tick();
      check($sformatf("vec%0d", i), {24'd0, m3}, {24'd0, vecs[i].exp});
    end

    // Mid-stream reset: data in flight, then reset between edges.
    cke = 1'b1; s_clear = 1'b0; s_valid = 1'b1;
    d0[7:0] = 8'h0f; d1[7:0] = 8'h0f;
    tick(); tick(); tick();
    check("pre_reset_stream", {24'd0, m3}, 32'hf0);
    #2 reset = 1'b0;
    #1;
    check("async_reset_now", {24'd0, m3}, 32'h0);
    d0[7:0] = 8'hff; d1[7:0] = 8'h00;
    tick();
    check("reset_ignores_edge", {24'd0, m3}, 32'h0);
    #2 reset = 1'b1;
    d0[7:0] = 8'hc3; d1[7:0] = 8'h0f;
    tick();
    check("restart_1", {24'd0, m3}, 32'h0);
    tick();
    check("restart_2", {24'd0, m3}, 32'h0);
    tick();
    check("restart_3", {24'd0, m3}, 32'hfc);

    // Random phase across all four latencies.
    reset = 1'b0;
    for (int l = 1; l <= 3; l++)
      for (int s = 0; s < 3; s++) mdl[l][s] = 32'h0;
    tick();
    reset = 1'b1;
    for (int c = 0; c < 300; c++) begin
      d0      = $urandom;
      d1      = ($urandom_range(0, 3) == 0) ? ~d0 : $urandom;
      cke     = ($urandom_range(0, 4) != 0);
      s_clear = ($urandom_range(0, 7) == 0);
      s_valid = ($urandom_range(0, 3) != 0);
      #1;
      check("rand_l0", {27'd0, m0},
            s_clear ? clear_of(0) : (~(d0 & d1) & width_mask(0)));
      tick();
      model_edge();
      check("rand_l1", {16'd0, m1}, mdl[1][0]);
      check("rand_l2", m2, mdl[2][1]);
      check("rand_l3", {24'd0, m3}, mdl[3][2]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
